// File: rtl/tv80_io_master_pkg.sv
// rtl/tv80_io_master_pkg.sv - shared encodings and constants for the TV80 I/O bus initiator
package tv80_io_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } io_state_e;

    localparam int         AUTO_CNT_W    = 3;
    localparam int         STALL_CNT_W   = 8;
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;
    localparam logic       STROBE_OFF    = 1'b1;

    // The bus strobes are low only while the cycle sits in T2 or a wait state.
    function automatic logic strobe_phase(input io_state_e s);
        return (s == ST_T2) || (s == ST_TW);
    endfunction

endpackage

// File: rtl/tv80_io_wait_timer.sv
// rtl/tv80_io_wait_timer.sv - auto wait-state down-counter and wait_n timeout up-counter
module tv80_io_wait_timer
    import tv80_io_master_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    input  logic stall,
    output logic auto_done,
    output logic timed_out
);

    localparam logic [AUTO_CNT_W-1:0]  WS_LOAD  = AUTO_CNT_W'(WAIT_STATES);
    localparam logic [STALL_CNT_W-1:0] TO_LIMIT = STALL_CNT_W'(TIMEOUT);

    logic [AUTO_CNT_W-1:0]  auto_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // auto_cnt holds the automatic wait cycles still owed; it starts ticking in T2,
    // so WAIT_STATES = 0 is already done when T2 is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt  <= '0;
            stall_cnt <= '0;
        end else if (start) begin
            auto_cnt  <= WS_LOAD;
            stall_cnt <= '0;
        end else begin
            if (run && (auto_cnt != '0)) begin
                auto_cnt <= auto_cnt - 1'b1;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign auto_done = (auto_cnt == '0);
    assign timed_out = (TO_LIMIT != '0) && (stall_cnt == TO_LIMIT);

endmodule

// File: rtl/tv80_io_master.sv
// rtl/tv80_io_master.sv - single-beat IN/OUT request initiator driving the Z80 I/O port cycle
module tv80_io_master
    import tv80_io_master_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] addr,
    output logic [7:0] DO,
    input  logic [7:0] DI,
    input  logic       wait_n
);

    io_state_e state;
    io_state_e state_nxt;

    logic wr_q;
    logic accept;
    logic in_strobe;
    logic next_strobe;
    logic stall;
    logic auto_done;
    logic timed_out;
    logic done_ok;
    logic done_abort;

    assign req_ready   = (state == ST_IDLE) || (state == ST_T3);
    assign accept      = req_valid && req_ready;
    assign in_strobe   = strobe_phase(state);
    assign next_strobe = strobe_phase(state_nxt);
    assign stall       = in_strobe && auto_done && !wait_n;

    tv80_io_wait_timer #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept),
        .run       (in_strobe),
        .stall     (stall),
        .auto_done (auto_done),
        .timed_out (timed_out)
    );

    always_comb begin
        state_nxt  = state;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_T1;
                end
            end
            ST_T1: begin
                state_nxt = ST_T2;
            end
            ST_T2, ST_TW: begin
                // A responder releasing wait_n on the same cycle the limit is hit still completes normally.
                if (auto_done && wait_n) begin
                    state_nxt = ST_T3;
                    done_ok   = 1'b1;
                end else if (timed_out) begin
                    state_nxt  = ST_T3;
                    done_abort = 1'b1;
                end else begin
                    state_nxt = ST_TW;
                end
            end
            ST_T3: begin
                state_nxt = accept ? ST_T1 : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wr_q      <= 1'b0;
            addr      <= '0;
            DO        <= '0;
            iorq_n    <= STROBE_OFF;
            rd_n      <= STROBE_OFF;
            wr_n      <= STROBE_OFF;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q <= req_write;
                addr <= req_addr;
                DO   <= req_wdata;
            end
            // Strobes follow the next state so they change on the edge that enters T2 or T3.
            iorq_n    <= next_strobe ? ~STROBE_OFF : STROBE_OFF;
            rd_n      <= (next_strobe && !wr_q) ? ~STROBE_OFF : STROBE_OFF;
            wr_n      <= (next_strobe && wr_q) ? ~STROBE_OFF : STROBE_OFF;
            rsp_valid <= done_ok || done_abort;
            if (done_abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= TIMEOUT_RDATA;
            end else if (done_ok) begin
                rsp_err <= 1'b0;
                if (!wr_q) begin
                    rsp_rdata <= DI;
                end
            end
        end
    end

endmodule
